embcpu_onchip_mem_arbiter: RTL and testbench

- Shares the single-port on-chip RAM (32-bit, 1024 words, byte enables) between two Avalon-MM masters, m0 and m1.
  - m0 is typically the CPU data master.
  - m1 is typically a DMA/debug master.
- Round-robin arbitration, one transfer accepted per cycle.
- Read data is returned with readdatavalid, tagged to the issuing master.
- Sits between the masters and the RAM wrapper's slave port, and drives its address, byteenable, chipselect, write and writedata.

---
 rtl/embcpu_onchip_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_embcpu_onchip_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/embcpu_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// Define EMBCPU_MEMARB_LOCK_EN to add m0_lock/m1_lock bus locking.
module embcpu_onchip_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

`ifdef EMBCPU_MEMARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0;
  logic req1;
  logic allow0;
  logic allow1;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;
  logic any_grant;
  logic rd_accept;
  logic last_grant;

  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef EMBCPU_MEMARB_LOCK_EN
  logic lock_active;
  logic lock_owner;
  logic win_lock;
  logic owner_req;

  assign allow0    = ~lock_active | ~lock_owner;
  assign allow1    = ~lock_active | lock_owner;
  assign win_lock  = grant1 ? m1_lock : m0_lock;
  assign owner_req = lock_owner ? req1 : req0;

  // A lock is taken by an accepted access with lock high and released by the
  // owner's first unlocked access or by the owner going idle for a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (lock_active) begin
      if (!owner_req || (any_grant && !win_lock)) begin
        lock_active <= 1'b0;
      end
    end else if (any_grant && win_lock) begin
      lock_active <= 1'b1;
      lock_owner  <= grant1;
    end
  end
`else
  assign allow0 = 1'b1;
  assign allow1 = 1'b1;
`endif

  // Gating with reset_n keeps both masters stalled while reset is held.
  assign elig0 = req0 & allow0 & reset_n;
  assign elig1 = req1 & allow1 & reset_n;

  assign grant0    = elig0 & (~elig1 | last_grant);
  assign grant1    = elig1 & (~elig0 | ~last_grant);
  assign any_grant = grant0 | grant1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (any_grant) begin
      last_grant <= grant1;
    end
  end

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (grant0) begin
      mem_write      = m0_write;
    end
  end

  assign mem_chipselect = any_grant;
  assign rd_accept      = any_grant & ~mem_write;

  // Read tags travel alongside the RAM latency so data returns to its issuer.
  generate
    if (RD_LATENCY > 1) begin : g_deep_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_valid <= '0;
          pipe_owner <= '0;
        end else begin
          pipe_valid <= {pipe_valid[RD_LATENCY-2:0], rd_accept};
          pipe_owner <= {pipe_owner[RD_LATENCY-2:0], grant1};
        end
      end
    end else begin : g_single_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_valid <= '0;
          pipe_owner <= '0;
        end else begin
          pipe_valid <= rd_accept;
          pipe_owner <= grant1;
        end
      end
    end
  endgenerate

  assign m0_waitrequest   = ~grant0;
  assign m1_waitrequest   = ~grant1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = pipe_valid[RD_LATENCY-1] & ~pipe_owner[RD_LATENCY-1];
  assign m1_readdatavalid = pipe_valid[RD_LATENCY-1] & pipe_owner[RD_LATENCY-1];

endmodule

// File: tb/tb_embcpu_onchip_mem_arbiter.sv
// Self-checking bench for embcpu_onchip_mem_arbiter: directed and random traffic
// from both masters checked against a transaction-level model of the arbiter.
module tb_embcpu_onchip_mem_arbiter;

  parameter int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef EMBCPU_MEMARB_LOCK_EN
  logic        m0_lock = 1'b0;
  logic        m1_lock = 1'b0;
`endif

  logic lockNext0 = 1'b0;
  logic lockNext1 = 1'b0;

  int checkCount = 0;
  int failCount  = 0;
  int cycleNum   = 0;
  int lastWinner = -1;

  always #5 clk = ~clk;

  embcpu_onchip_mem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .BE_W(4), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef EMBCPU_MEMARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with byte enables and RD_LAT read latency.
  function automatic logic [31:0] initWord(input int i);
    return {16'(i) ^ 16'hA5A5, ~16'(i)};
  endfunction

  logic [31:0] ram [0:1023];
  logic [31:0] q1 = '0;
  logic [31:0] q2 = '0;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = initWord(i);
  end

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        q1 <= ram[mem_address];
      end
    end
    q2 <= q1;
  end

  assign mem_readdata = (RD_LAT == 2) ? q2 : q1;

  // Reference model: shadow memory, grant history and expected read returns.
  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } rd_t;

  logic [31:0] shadow [0:1023];
  rd_t         expQ[$];
  int          mLastGrant  = 1;
  bit          mLockActive = 1'b0;
  int          mLockOwner  = 0;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = initWord(i);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cycleNum);
    end
  endtask

  task automatic driveIdle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    lockNext0 = 1'b0; lockNext1 = 1'b0;
`ifdef EMBCPU_MEMARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
  endtask

  // One bus cycle: drive both masters, check DUT outputs, advance the model.
  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [9:0] a0, input logic [3:0] be0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [9:0] a1, input logic [3:0] be1, input logic [31:0] d1);
    int          win;
    bit          ok0, ok1, req0, req1, wr, exp0, exp1, winLock;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data, expData;
    rd_t         ent;

    @(negedge clk);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
`ifdef EMBCPU_MEMARB_LOCK_EN
    m0_lock = lockNext0; m1_lock = lockNext1;
`endif
    cycleNum++;
    #2;

    req0 = r0 | w0;
    req1 = r1 | w1;
    ok0  = req0 && (!mLockActive || mLockOwner == 0);
    ok1  = req1 && (!mLockActive || mLockOwner == 1);
    if (ok0 && ok1)  win = (mLastGrant == 0) ? 1 : 0;
    else if (ok0)    win = 0;
    else if (ok1)    win = 1;
    else             win = -1;

    wr   = (win == 1) ? w1 : w0;
    addr = (win == 1) ? a1 : a0;
    be   = (win == 1) ? be1 : be0;
    data = (win == 1) ? d1 : d0;

    checkOutput("m0_waitrequest", 32'(m0_waitrequest), 32'(win != 0));
    checkOutput("m1_waitrequest", 32'(m1_waitrequest), 32'(win != 1));
    checkOutput("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0));
    if (win >= 0) begin
      checkOutput("mem_write", 32'(mem_write), 32'(wr));
      checkOutput("mem_address", 32'(mem_address), 32'(addr));
    end else begin
      checkOutput("mem_write_idle", 32'(mem_write), 32'd0);
    end

    exp0 = 1'b0; exp1 = 1'b0; expData = '0;
    if (expQ.size() > 0 && expQ[0].due == cycleNum) begin
      ent = expQ.pop_front();
      if (ent.owner == 0) exp0 = 1'b1; else exp1 = 1'b1;
      expData = ent.data;
    end
    checkOutput("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp0));
    checkOutput("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp1));
    if (exp0) checkOutput("m0_readdata", m0_readdata, expData);
    if (exp1) checkOutput("m1_readdata", m1_readdata, expData);

    if (win >= 0) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[addr][8*b +: 8] = data[8*b +: 8];
      end else begin
        ent.due = cycleNum + RD_LAT; ent.owner = win; ent.data = shadow[addr];
        expQ.push_back(ent);
      end
      mLastGrant = win;
    end

    winLock = (win == 1) ? lockNext1 : lockNext0;
    if (mLockActive) begin
      if (!((mLockOwner == 1) ? req1 : req0) || (win >= 0 && !winLock)) mLockActive = 1'b0;
    end else if (win >= 0 && winLock) begin
      mLockActive = 1'b1;
      mLockOwner  = win;
    end
    lastWinner = win;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  // Asynchronous reset mid-cycle while both masters request and reads may be in flight.
  task automatic doReset();
    @(negedge clk);
    driveIdle();
    #1;
    reset_n = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1;
    #1;
    checkOutput("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    checkOutput("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    checkOutput("rst_mem_chipselect", 32'(mem_chipselect), 32'd0);
    checkOutput("rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    checkOutput("rst_m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    checkOutput("rst_hold_readdatavalid", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
    driveIdle();
    reset_n = 1'b1;
    expQ.delete();
    mLastGrant  = 1;
    mLockActive = 1'b0;
  endtask

  initial begin
    int n0, n1;
    logic r0, w0, r1, w1;

    driveIdle();
    reset_n = 1'b0;
    #12;
    checkOutput("reset_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    checkOutput("reset_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    checkOutput("reset_mem_chipselect", 32'(mem_chipselect), 32'd0);
    checkOutput("reset_readdatavalid", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] single master write then read");
    applyStimulus(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 10'h005, 4'hF, '0,           0, 0, '0, '0, '0);
    idleCycles(3);

    $display("[TB] byte-enable merge across masters");
    applyStimulus(0, 1, 10'h020, 4'hF, 32'h11223344, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, '0,                  0, 1, 10'h020, 4'h5, 32'hAABBCCDD);
    applyStimulus(1, 0, 10'h020, 4'hF, '0,           0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, '0,                  1, 0, 10'h020, 4'hF, '0);
    idleCycles(3);

    $display("[TB] both masters reading continuously");
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 10'(10'h010 + n0), 4'hF, '0, 1, 0, 10'(10'h200 + n1), 4'hF, '0);
      if (lastWinner == 0) n0++;
      else if (lastWinner == 1) n1++;
    end
    idleCycles(3);

    $display("[TB] back-to-back m1 reads");
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'h005, 4'hF, '0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'h020, 4'hF, '0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'h011, 4'hF, '0);
    idleCycles(4);

    $display("[TB] reset with a read in flight");
    applyStimulus(1, 0, 10'h005, 4'hF, '0, 0, 0, '0, '0, '0);
    doReset();
    idleCycles(3);
    applyStimulus(1, 0, 10'h005, 4'hF, '0, 1, 0, 10'h020, 4'hF, '0);
    idleCycles(3);

`ifdef EMBCPU_MEMARB_LOCK_EN
    $display("[TB] m1 locked burst");
    applyStimulus(0, 1, 10'h030, 4'hF, 32'h0000_0030, 0, 0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      lockNext1 = (k < 3);
      applyStimulus(0, 1, 10'h031, 4'hF, 32'h0000_0031, 0, 1, 10'(10'h040 + k), 4'hF, 32'(k));
    end
    lockNext1 = 1'b0;
    applyStimulus(0, 1, 10'h031, 4'hF, 32'h0000_0031, 0, 0, '0, '0, '0);
    idleCycles(2);
`endif

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      r0 = (n0 == 1) || (n0 == 2); w0 = (n0 == 3);
      r1 = (n1 == 1) || (n1 == 2); w1 = (n1 == 3);
`ifdef EMBCPU_MEMARB_LOCK_EN
      lockNext0 = ($urandom_range(0, 3) == 0);
      lockNext1 = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(r0, w0, 10'($urandom_range(0, 15)), 4'($urandom), $urandom,
                    r1, w1, 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
      if ($urandom_range(0, 99) == 0) doReset();
    end
    lockNext0 = 1'b0;
    lockNext1 = 1'b0;

    idleCycles(RD_LAT + 3);
    checkOutput("pending_reads_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
